// File: rtl/l2_responder_if.sv
// Request/response bundle between an upper-level cache (master) and the
// l2_responder (slave).
interface l2_responder_if;
   logic         enable_in;
   logic         write_enable_in;
   logic [63:0]  write_data_in;
   logic [63:0]  address_in;
   logic [2:0]   write_size_in;
   logic         clf_in;
   logic         enable_out;
   logic         resp_valid;
   logic [127:0] data_out;
   logic         err_out;
   logic [31:0]  req_count;

   modport master (
      output enable_in, write_enable_in, write_data_in, address_in,
             write_size_in, clf_in,
      input  enable_out, resp_valid, data_out, err_out, req_count
   );

   modport slave (
      input  enable_in, write_enable_in, write_data_in, address_in,
             write_size_in, clf_in,
      output enable_out, resp_valid, data_out, err_out, req_count
   );
endinterface

// File: rtl/l2_responder.sv
// Fixed-latency L2 model: 2^IDX_BITS lines of 128 bits serving one read,
// sub-line write or line flush at a time, answered with a single-cycle pulse.
module l2_responder #(
   parameter int LATENCY  = 4,
   parameter int IDX_BITS = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   l2_responder_if.slave bus
);
   localparam int LINES = 1 << IDX_BITS;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_BUSY     = 2'd1;
   localparam logic [1:0] S_RESP     = 2'd2;
   localparam logic [1:0] S_WAIT_REL = 2'd3;

   logic [1:0]          state_reg;
   logic [3:0]          cnt_reg;
   logic                we_reg;
   logic                clf_reg;
   logic [63:0]         wdata_reg;
   logic [IDX_BITS-1:0] idx_reg;
   logic [3:0]          off_reg;
   logic [2:0]          size_reg;
   logic [127:0]        data_reg;
   logic                err_reg;
   logic [31:0]         count_reg;
   logic                en_out_reg;
   logic [127:0]        line_reg [LINES];

   logic [127:0] cur_line;
   logic [4:0]   num_bytes;
   logic         req_err;
   logic [15:0]  byte_mask;
   logic [127:0] bit_mask;
   logic [127:0] shifted;
   logic [127:0] merged;
   logic         fire;
   logic         line_we;
   logic [127:0] line_wdata;
   logic [127:0] resp_data;

   assign cur_line  = line_reg[idx_reg];
   assign num_bytes = 5'd1 << size_reg[1:0];
   assign req_err   = size_reg[2] | (({1'b0, off_reg} + num_bytes) > 5'd16);
   assign byte_mask = ((16'd1 << num_bytes) - 16'd1) << off_reg;
   assign shifted   = {64'd0, wdata_reg} << {off_reg, 3'b000};

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_mask
         assign bit_mask[gi*8 +: 8] = {8{byte_mask[gi]}};
      end
   endgenerate

   assign merged = (cur_line & ~bit_mask) | (shifted & bit_mask);

   // The array is touched only on the edge that enters RESP, and never on error.
   assign fire       = (state_reg == S_BUSY) && (cnt_reg == 4'd0);
   assign line_we    = fire && !req_err && (clf_reg || we_reg);
   assign line_wdata = clf_reg ? 128'd0 : merged;
   assign resp_data  = req_err ? 128'd0 :
                       (clf_reg ? cur_line : (we_reg ? merged : cur_line));

   generate
      for (gi = 0; gi < LINES; gi++) begin : g_line
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               line_reg[gi] <= '0;
            end else if (line_we && (idx_reg == IDX_BITS'(gi))) begin
               line_reg[gi] <= line_wdata;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         we_reg     <= 1'b0;
         clf_reg    <= 1'b0;
         wdata_reg  <= '0;
         idx_reg    <= '0;
         off_reg    <= '0;
         size_reg   <= '0;
         data_reg   <= '0;
         err_reg    <= 1'b0;
         count_reg  <= '0;
         en_out_reg <= 1'b1;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (!bus.enable_in) begin
                  we_reg     <= bus.write_enable_in;
                  clf_reg    <= bus.clf_in;
                  wdata_reg  <= bus.write_data_in;
                  idx_reg    <= bus.address_in[IDX_BITS+3:4];
                  off_reg    <= bus.address_in[3:0];
                  size_reg   <= bus.write_size_in;
                  cnt_reg    <= 4'(LATENCY - 1);
                  en_out_reg <= 1'b0;
                  state_reg  <= S_BUSY;
               end
            end
            S_BUSY: begin
               // Counter runs LATENCY-1 .. 0, so RESP starts on the LATENCY-th edge after capture.
               if (cnt_reg == 4'd0) begin
                  data_reg  <= resp_data;
                  err_reg   <= req_err;
                  count_reg <= count_reg + 32'd1;
                  state_reg <= S_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            S_RESP: begin
               data_reg <= '0;
               err_reg  <= 1'b0;
               if (bus.enable_in) begin
                  en_out_reg <= 1'b1;
                  state_reg  <= S_IDLE;
               end else begin
                  state_reg <= S_WAIT_REL;
               end
            end
            default: begin
               if (bus.enable_in) begin
                  en_out_reg <= 1'b1;
                  state_reg  <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.enable_out = en_out_reg;
   assign bus.resp_valid = (state_reg == S_RESP);
   assign bus.err_out    = err_reg;
   assign bus.data_out   = data_reg;
   assign bus.req_count  = count_reg;
endmodule

// File: tb/tb_l2_responder.sv
// Randomised scoreboard bench for l2_responder: a byte-level array model predicts
// each response; a negedge monitor checks data, error flag, count and latency.
module tb_l2_responder;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   l2_responder_if bus ();

   l2_responder #(.LATENCY(LAT), .IDX_BITS(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [127:0] data;
      logic         err;
      logic [31:0]  cnt;
      int           at;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] mem [64];
   logic [31:0]  m_count;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every response must match the oldest outstanding prediction.
   always @(negedge clk) begin
      if (rst_n && bus.resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_data", bus.data_out, e.data);
            chk("resp_err", 128'(bus.err_out), 128'(e.err));
            chk("resp_count", 128'(bus.req_count), 128'(e.cnt));
            chk("resp_latency", 128'(cyc), 128'(e.at));
            $display("[TB] resp cyc=%0d err=%0b cnt=%0d data=%h", cyc, bus.err_out, bus.req_count, bus.data_out);
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mem[i] = '0;
      m_count = '0;
      sb.delete();
   endtask

   task automatic start_req(input logic we, input logic clf, input logic [63:0] addr,
                            input logic [2:0] sz, input logic [63:0] d);
      int   t;
      int   nb;
      int   off;
      int   idx;
      exp_t e;
      t = 0;
      while (bus.enable_out !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout: got enable_out=%b expected 1", bus.enable_out);
      end
      bus.write_enable_in = we;
      bus.clf_in          = clf;
      bus.address_in      = addr;
      bus.write_size_in   = sz;
      bus.write_data_in   = d;
      bus.enable_in       = 1'b0;
      nb  = 1 << int'(sz);
      off = int'(addr[3:0]);
      idx = int'(addr[9:4]);
      if (sz > 3'd3 || off + nb > 16) begin
         e.data = '0;
         e.err  = 1'b1;
      end else if (clf) begin
         e.data   = mem[idx];
         mem[idx] = '0;
         e.err    = 1'b0;
      end else begin
         if (we) begin
            for (int b = 0; b < nb; b++) mem[idx][(off + b)*8 +: 8] = d[b*8 +: 8];
         end
         e.data = mem[idx];
         e.err  = 1'b0;
      end
      m_count = m_count + 32'd1;
      e.cnt   = m_count;
      e.at    = cyc + 1 + LAT;
      sb.push_back(e);
      $display("[TB] req  cyc=%0d we=%0b clf=%0b addr=%h size=%0d data=%h", cyc + 1, we, clf, addr, sz, d);
      @(negedge clk);
      // Scramble request inputs after capture; the in-flight operation must ignore them.
      bus.write_enable_in = 1'($urandom);
      bus.clf_in          = 1'($urandom);
      bus.address_in      = {$urandom, $urandom};
      bus.write_size_in   = 3'($urandom);
      bus.write_data_in   = {$urandom, $urandom};
   endtask

   task automatic finish_req(input int hold);
      int t;
      t = 0;
      while (bus.resp_valid !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         tests++;
         fails++;
         $display("FAIL resp_timeout: got resp_valid=%b expected 1", bus.resp_valid);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_enable_out", 128'(bus.enable_out), 128'(0));
      end
      bus.enable_in = 1'b1;
      @(negedge clk);
      chk("release_enable_out", 128'(bus.enable_out), 128'(1));
   endtask

   task automatic do_req(input logic we, input logic clf, input logic [63:0] addr,
                         input logic [2:0] sz, input logic [63:0] d, input int hold);
      start_req(we, clf, addr, sz, d);
      finish_req(hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.enable_in       = 1'b1;
      bus.write_enable_in = 1'b0;
      bus.clf_in          = 1'b0;
      bus.address_in      = '0;
      bus.write_size_in   = '0;
      bus.write_data_in   = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_enable_out", 128'(bus.enable_out), 128'(1));
      chk("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
      chk("rst_err_out", 128'(bus.err_out), 128'(0));
      chk("rst_data_out", bus.data_out, 128'd0);
      chk("rst_req_count", 128'(bus.req_count), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      do_req(1'b0, 1'b0, 64'h40, 3'd0, 64'd0, 0);
      do_req(1'b1, 1'b0, 64'h48, 3'd3, 64'h1122334455667788, 0);
      do_req(1'b0, 1'b0, 64'h40, 3'd0, 64'd0, 0);
      do_req(1'b1, 1'b0, 64'h0F, 3'd1, 64'hABCD, 0);
      do_req(1'b1, 1'b0, 64'h00, 3'd5, 64'h55, 0);
      do_req(1'b0, 1'b0, 64'h00, 3'd0, 64'd0, 0);
      do_req(1'b0, 1'b1, 64'h48, 3'd0, 64'd0, 0);
      do_req(1'b0, 1'b0, 64'h40, 3'd0, 64'd0, 0);
      do_req(1'b1, 1'b0, 64'h1C, 3'd2, 64'hDEADBEEF, 3);

      for (int n = 0; n < 150; n++) begin
         logic [63:0] a;
         logic [2:0]  sz;
         int          r;
         int          op;
         a      = {$urandom, $urandom};
         a[9:4] = 6'($urandom_range(0, 7));
         r      = $urandom_range(0, 9);
         sz     = (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 7));
         op     = $urandom_range(0, 9);
         start_req(op >= 1 && op <= 4, op == 0, a, sz, {$urandom, $urandom});
         finish_req(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end

      // Reset while a write is in flight: no response, array and count cleared.
      start_req(1'b1, 1'b0, 64'h80, 3'd3, 64'hCAFEF00D12345678);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_enable_out", 128'(bus.enable_out), 128'(1));
      chk("midrst_resp_valid", 128'(bus.resp_valid), 128'(0));
      chk("midrst_req_count", 128'(bus.req_count), 128'(0));
      bus.enable_in = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_req(1'b0, 1'b0, 64'h80, 3'd0, 64'd0, 0);
      do_req(1'b0, 1'b0, 64'h40, 3'd0, 64'd0, 1);

      repeat (4) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
